// File: rtl/layer_pkg.sv
// Shared definitions for the two-input layer blocks.
// Holds the default word width and the pair-collection FSM state type.
package layer_pkg;

    localparam int WORD_SIZE_DEF = 16;

    typedef enum logic [1:0] {
        eEMPTY = 2'd0,
        eHALF  = 2'd1,
        eFULL  = 2'd2
    } pair_state_e;

endpackage

// File: rtl/pair_deserializer.sv
// Collects two consecutive upstream words and presents them as one parallel pair.
// Define PAIR_DESERIALIZER_SWAP_EN to present the second accepted word on data1_r_o.
module pair_deserializer
    import layer_pkg::*;
#(
    parameter int WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [WORD_SIZE-1:0] data_r_i,
    output logic        [1:0]           valid_o,
    input  logic                        ready_i,
    output logic signed [WORD_SIZE-1:0] data1_r_o,
    output logic signed [WORD_SIZE-1:0] data2_r_o
);

    pair_state_e state_q, state_d;
    logic signed [WORD_SIZE-1:0] word1_q, word1_d;
    logic signed [WORD_SIZE-1:0] word2_q, word2_d;
    logic up_xfer;
    logic dn_xfer;

    assign ready_o = (state_q != eFULL) || ready_i;
    assign up_xfer = valid_i && ready_o;
    assign dn_xfer = (state_q == eFULL) && ready_i;

    always_comb begin
        state_d = state_q;
        word1_d = word1_q;
        word2_d = word2_q;
        valid_o = 2'b00;
        unique case (state_q)
            eEMPTY: begin
                if (up_xfer) begin
                    state_d = eHALF;
                    word1_d = data_r_i;
                end
            end
            eHALF: begin
                valid_o = 2'b01;
                if (up_xfer) begin
                    state_d = eFULL;
                    word2_d = data_r_i;
                end
            end
            eFULL: begin
                valid_o = 2'b11;
                // A pair leaving while a new word arrives restarts at word1 with no bubble
                if (dn_xfer && up_xfer) begin
                    state_d = eHALF;
                    word1_d = data_r_i;
                end else if (dn_xfer) begin
                    state_d = eEMPTY;
                end
            end
            default: begin
                state_d = eEMPTY;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= eEMPTY;
            word1_q <= '0;
            word2_q <= '0;
        end else begin
            state_q <= state_d;
            word1_q <= word1_d;
            word2_q <= word2_d;
        end
    end

`ifdef PAIR_DESERIALIZER_SWAP_EN
    assign data1_r_o = word2_q;
    assign data2_r_o = word1_q;
`else
    assign data1_r_o = word1_q;
    assign data2_r_o = word2_q;
`endif

endmodule

// File: tb/tb_pair_deserializer.sv
// Directed and random checks of pair_deserializer against a scoreboard of expected pairs.
// Define PAIR_DESERIALIZER_SWAP_EN to check the swapped output order.
module tb_pair_deserializer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_i;
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] data_r_i;
    logic [1:0]   valid_o;
    logic         ready_i;
    logic [W-1:0] data1_r_o;
    logic [W-1:0] data2_r_o;

    int checks = 0;
    int errors = 0;

    // Bench model: number of words held and the expected pair queue
    int             mstate = 0;
    logic [W-1:0]   w1;
    logic [2*W-1:0] sb[$];
    int             accepted = 0;

    always #5 clk = ~clk;

    pair_deserializer #(.WORD_SIZE(W)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data_r_i (data_r_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .data1_r_o(data1_r_o),
        .data2_r_o(data2_r_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [W-1:0] d, input logic r);
        logic up, dn;
        logic [2*W-1:0] fr;
        valid_i  = v;
        data_r_i = d;
        ready_i  = r;
        #1;
        chk("valid_o", 32'(valid_o), (mstate == 0) ? 32'd0 : (mstate == 1) ? 32'd1 : 32'd3);
        chk("ready_o", 32'(ready_o), 32'((mstate != 2) || r));
        if (mstate == 2) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                fr = sb[0];
                chk("data1_r_o", 32'(data1_r_o), 32'(fr[2*W-1:W]));
                chk("data2_r_o", 32'(data2_r_o), 32'(fr[W-1:0]));
            end
        end
        up = v && ((mstate != 2) || r);
        dn = (mstate == 2) && r;
        if (dn && sb.size() != 0) void'(sb.pop_front());
        if (up) begin
            accepted++;
            if (mstate == 1) begin
`ifdef PAIR_DESERIALIZER_SWAP_EN
                sb.push_back({d, w1});
`else
                sb.push_back({w1, d});
`endif
            end else begin
                w1 = d;
            end
        end
        if (dn) mstate = up ? 1 : 0;
        else if (up) mstate = mstate + 1;
        @(negedge clk);
    endtask

    initial begin
        int budget;
        reset_i  = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        data_r_i = '0;
        #1;
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_data1", 32'(data1_r_o), 32'd0);
        chk("rst_data2", 32'(data2_r_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;

        // Basic pair
        cyc(1'b1, 16'h0698, 1'b1);
        cyc(1'b1, 16'hF105, 1'b1);
        cyc(1'b0, 16'h1234, 1'b1);
        cyc(1'b0, 16'h5678, 1'b1);

        // Continuous stream, ready_o must stay high
        cyc(1'b1, 16'hF8DD, 1'b1);
        cyc(1'b1, 16'hF17A, 1'b1);
        cyc(1'b1, 16'hF31C, 1'b1);
        cyc(1'b1, 16'h063C, 1'b1);
        cyc(1'b0, 16'hAAAA, 1'b1);

        // Stall in eFULL with upstream pushing
        cyc(1'b1, 16'h1111, 1'b1);
        cyc(1'b1, 16'h2222, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h3333 + 16'(i), 1'b0);
        cyc(1'b1, 16'h4444, 1'b1);
        cyc(1'b1, 16'h5555, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);

        // Async reset while holding word1
        cyc(1'b1, 16'h0698, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_valid_o", 32'(valid_o), 32'd0);
        chk("arst_ready_o", 32'(ready_o), 32'd1);
        chk("arst_data1", 32'(data1_r_o), 32'd0);
        mstate = 0;
        sb.delete();
        @(negedge clk);
        reset_i = 1'b0;
        cyc(1'b1, 16'h0001, 1'b1);
        cyc(1'b1, 16'h0002, 1'b1);
        cyc(1'b0, 16'h0003, 1'b1);

        // Random handshake over 1000 words
        accepted = 0;
        budget = 0;
        while (accepted < 1000 && budget < 20000) begin
            cyc(1'($urandom_range(0, 9) < 7), W'($urandom),
                1'($urandom_range(0, 9) < 6));
            budget++;
        end
        chk("rand_budget", 32'(accepted >= 1000), 32'd1);
        budget = 0;
        while (mstate == 2 && budget < 10) begin
            cyc(1'b0, 16'h0, 1'b1);
            budget++;
        end
        cyc(1'b0, 16'h0, 1'b1);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
